// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
// The requester id doubles as the round-robin "last granted" marker.
package mem_arb_pkg;
   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_WAIT_CYCLES = 2;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;
endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter timing the memory strobe window: load, decrement, zero flag.
module mem_wait_counter
   import mem_arb_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one asynchronous-style memory between a CPU (A)
// and a loader (B); every output is registered so strobes never glitch.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              busy
);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

   state_t              state_q, state_d;
   req_id_t             grant_q, grant_d;
   req_id_t             last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic                busy_q, busy_d;
   logic                mem_oe_n_q, mem_oe_n_d;
   logic                mem_we_n_q, mem_we_n_d;
   logic                cnt_load, cnt_dec, cnt_zero;

   mem_wait_counter #(.W(CNT_W)) u_wait (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               // On a tie the port that did not win last time gets the bus.
               if (a_req && b_req) begin
                  grant_d = (last_q == REQ_A) ? REQ_B : REQ_A;
               end else begin
                  grant_d = a_req ? REQ_A : REQ_B;
               end
               last_d      = grant_d;
               we_d        = (grant_d == REQ_A) ? a_we    : b_we;
               mem_addr_d  = (grant_d == REQ_A) ? a_addr  : b_addr;
               mem_wdata_d = (grant_d == REQ_A) ? a_wdata : b_wdata;
               cnt_load    = 1'b1;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with it.
      busy_d     = (state_d != IDLE);
      mem_oe_n_d = !((state_d == ACCESS) && !we_d);
      mem_we_n_d = !((state_d == ACCESS) && we_d);
      a_ack_d    = (state_d == DONE) && (grant_d == REQ_A);
      b_ack_d    = (state_d == DONE) && (grant_d == REQ_B);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         grant_q     <= REQ_A;
         last_q      <= REQ_B;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_oe_n_q  <= 1'b1;
         mem_we_n_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         busy_q      <= busy_d;
         mem_oe_n_q  <= mem_oe_n_d;
         mem_we_n_q  <= mem_we_n_d;
      end
   end

   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_oe_n  = mem_oe_n_q;
   assign mem_we_n  = mem_we_n_q;
   assign busy      = busy_q;
endmodule
